// File: rtl/vga_scanout_if.sv
// ---------------------------------------------------------------------------
// vga_scanout_if
// Groups the scan-out client's non-clock signals into one bundle:
//   enable        - scan control from the system (1 = scan)
//   r_x_address   - framebuffer read column (client -> framebuffer)
//   r_y_address   - framebuffer read row    (client -> framebuffer)
//   rd_data       - framebuffer read byte, RGB332, one clock after address
//   vga_r/g/b     - 8-bit DAC channels
//   vga_hs/vs     - sync pins
//   vga_blank_n   - high during visible pixels
//   vga_sync_n    - tied low (no sync-on-green)
//   frame_start   - one-clock pulse with pixel (0,0) at the pins
// master: the scan-out block.  slave: its surroundings (framebuffer, DAC, host).
// ---------------------------------------------------------------------------
interface vga_scanout_if;
  logic       enable;
  logic [9:0] r_x_address;
  logic [9:0] r_y_address;
  logic [7:0] rd_data;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic       frame_start;

  modport master (
    input  enable,
    input  rd_data,
    output r_x_address,
    output r_y_address,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hs,
    output vga_vs,
    output vga_blank_n,
    output vga_sync_n,
    output frame_start
  );

  modport slave (
    output enable,
    output rd_data,
    input  r_x_address,
    input  r_y_address,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hs,
    input  vga_vs,
    input  vga_blank_n,
    input  vga_sync_n,
    input  frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
// Read-side client of the 640x480 RGB332 framebuffer. Generates VGA timing,
// issues one read address per pixel clock and expands the returned byte to
// 8 bits per channel. Every pin output is two clocks behind the counters:
// one clock for the framebuffer's registered read, one for the output regs.
// Ports:
//   clk    - pixel clock, also the framebuffer read clock
//   rst_n  - asynchronous active-low reset
//   bus    - vga_scanout_if.master (framebuffer read port, DAC pins, control)
// ---------------------------------------------------------------------------
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_scanout_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

  // Stage 0: raster counters
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Stage 0 decode (combinational from the counters)
  logic active0, hs0, vs0, frame0;

  // Stage 1: timing flags aligned with rd_data
  logic active1_q, active1_d;
  logic hs1_q, hs1_d;
  logic vs1_q, vs1_d;
  logic frame1_q, frame1_d;

  // Stage 2: pin registers
  logic [7:0] vga_r_q, vga_r_d;
  logic [7:0] vga_g_q, vga_g_d;
  logic [7:0] vga_b_q, vga_b_d;
  logic       hs_pin_q, hs_pin_d;
  logic       vs_pin_q, vs_pin_d;
  logic       blank_n_q, blank_n_d;
  logic       frame_start_q, frame_start_d;

  // Blue has only two source bits; repeat them across the byte.
  logic [7:0] b_expand;
  for (genvar gi = 0; gi < 4; gi++) begin : g_b_rep
    assign b_expand[2*gi +: 2] = bus.rd_data[1:0];
  end

  // Counters: disabled means parked at the frame origin, so the first
  // enabled cycle is always (0,0).
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!bus.enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  // Decode is gated by enable so that dropping enable blanks the pipe
  // in the same cycle, even though the counters only clear on the next edge.
  always_comb begin
    active0 = bus.enable && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs0     = bus.enable && (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C);
    vs0     = bus.enable && (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C);
    frame0  = bus.enable && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  // Addresses go straight out of stage 0; the framebuffer adds the one
  // clock that stage 1 compensates for.
  assign bus.r_x_address = active0 ? h_cnt_q : '0;
  assign bus.r_y_address = active0 ? v_cnt_q : '0;

  always_comb begin
    active1_d = active0;
    hs1_d     = hs0;
    vs1_d     = vs0;
    frame1_d  = frame0;

    // RGB332 -> 888 by bit replication so full-scale maps to 0xFF.
    if (active1_q) begin
      vga_r_d = {bus.rd_data[7:5], bus.rd_data[7:5], bus.rd_data[7:6]};
      vga_g_d = {bus.rd_data[4:2], bus.rd_data[4:2], bus.rd_data[4:3]};
      vga_b_d = b_expand;
    end else begin
      vga_r_d = '0;
      vga_g_d = '0;
      vga_b_d = '0;
    end

    blank_n_d     = active1_q;
    hs_pin_d      = hs1_q ? SYNC_POL : ~SYNC_POL;
    vs_pin_d      = vs1_q ? SYNC_POL : ~SYNC_POL;
    frame_start_d = frame1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active1_q     <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      frame1_q      <= 1'b0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      hs_pin_q      <= ~SYNC_POL;
      vs_pin_q      <= ~SYNC_POL;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      active1_q     <= active1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      frame1_q      <= frame1_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      hs_pin_q      <= hs_pin_d;
      vs_pin_q      <= vs_pin_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.vga_r       = vga_r_q;
  assign bus.vga_g       = vga_g_q;
  assign bus.vga_b       = vga_b_q;
  assign bus.vga_hs      = hs_pin_q;
  assign bus.vga_vs      = vs_pin_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
// Scoreboard bench for vga_scanout. Horizontal timing is the full 800-clock
// line; the vertical extent is shortened (4 visible lines, 9 total) so whole
// frames fit in a short run. Expected pin bundles, addresses and directed
// spot values are queued by the stimulus side and popped by a monitor.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int VA      = 4;
  localparam int V_TOT   = 9;
  localparam int VS_BEG  = 5;
  localparam int VS_END  = 7;
  localparam int H_TOT   = 800;
  localparam int FRAME   = H_TOT * V_TOT;

  localparam int SIG_BLANK = 0;
  localparam int SIG_HS    = 1;
  localparam int SIG_VS    = 2;
  localparam int SIG_FS    = 3;
  localparam int SIG_R     = 4;
  localparam int SIG_X     = 5;
  localparam int SIG_Y     = 6;

  typedef struct {
    int         due;
    int         h;
    int         v;
    bit         act;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       fs;
  } pin_t;

  typedef struct {
    int         due;
    logic [9:0] x;
    logic [9:0] y;
  } addr_t;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
  } dir_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  int   m_h = 0;
  int   m_v = 0;
  bit   tb_act0 = 1'b0;
  bit   meas_en = 1'b0;

  pin_t  pin_q[$];
  addr_t addr_q[$];
  dir_t  dir_q[$];

  vga_scanout_if bus_if ();

  vga_scanout #(
    .V_ACTIVE(VA),
    .V_FP(1),
    .V_SYNC(2),
    .V_BP(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Framebuffer model: pixel(x,y) = x ^ y; returns 0xFF whenever the
  // current cycle is not a visible one so that blanking is exercised.
  always @(posedge clk)
    bus_if.rd_data <= tb_act0 ? (bus_if.r_x_address[7:0] ^ bus_if.r_y_address[7:0]) : 8'hFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic string sig_name(input int s);
    case (s)
      SIG_BLANK: return "dir_blank_n";
      SIG_HS:    return "dir_hs";
      SIG_VS:    return "dir_vs";
      SIG_FS:    return "dir_frame_start";
      SIG_R:     return "dir_vga_r";
      SIG_X:     return "dir_x_addr";
      default:   return "dir_y_addr";
    endcase
  endfunction

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      SIG_BLANK: return 32'(bus_if.vga_blank_n);
      SIG_HS:    return 32'(bus_if.vga_hs);
      SIG_VS:    return 32'(bus_if.vga_vs);
      SIG_FS:    return 32'(bus_if.frame_start);
      SIG_R:     return 32'(bus_if.vga_r);
      SIG_X:     return 32'(bus_if.r_x_address);
      default:   return 32'(bus_if.r_y_address);
    endcase
  endfunction

  task automatic push_dir(input int due, input int sig, input logic [31:0] exp);
    dir_t d;
    d.due = due;
    d.sig = sig;
    d.exp = exp;
    dir_q.push_back(d);
  endtask

  function automatic pin_t idle_pins(input int due);
    pin_t e;
    e.due = due; e.h = -1; e.v = -1; e.act = 1'b0;
    e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
    e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    return e;
  endfunction

  // Reference model: evaluates the raster position of the current cycle and
  // queues what the pins must show two clocks later.
  always @(negedge clk) begin
    pin_t       e;
    addr_t      a;
    bit         en;
    logic [7:0] d;
    en = (bus_if.enable === 1'b1);
    if (rst_n !== 1'b1) begin
      pin_q.delete();
      pin_q.push_back(idle_pins(cyc));
      pin_q.push_back(idle_pins(cyc + 1));
      pin_q.push_back(idle_pins(cyc + 2));
      a.due = cyc; a.x = '0; a.y = '0;
      addr_q.push_back(a);
      m_h = 0;
      m_v = 0;
      tb_act0 = 1'b0;
    end else begin
      e = idle_pins(cyc + 2);
      e.h   = m_h;
      e.v   = m_v;
      e.act = en && (m_h < 640) && (m_v < VA);
      e.hs  = !(en && (m_h >= 656) && (m_h < 752));
      e.vs  = !(en && (m_v >= VS_BEG) && (m_v < VS_END));
      e.fs  = en && (m_h == 0) && (m_v == 0);
      if (e.act) begin
        d   = 8'(m_h ^ m_v);
        e.r = {d[7:5], d[7:5], d[7:6]};
        e.g = {d[4:2], d[4:2], d[4:3]};
        e.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
      end
      pin_q.push_back(e);
      a.due = cyc;
      a.x   = e.act ? 10'(m_h) : 10'd0;
      a.y   = e.act ? 10'(m_v) : 10'd0;
      addr_q.push_back(a);
      tb_act0 = e.act;
      if (!en) begin
        m_h = 0;
        m_v = 0;
      end else if (m_h == H_TOT - 1) begin
        m_h = 0;
        m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  end

  // Monitor: pops everything due this cycle and compares with the pins.
  always begin
    pin_t  e;
    addr_t a;
    dir_t  d;
    @(negedge clk);
    #2;
    while (pin_q.size() > 0 && pin_q[0].due < cyc) begin
      e = pin_q.pop_front();
      chk("sb_stale_pin", 64'(e.due), 64'(cyc));
    end
    if (pin_q.size() == 0 || pin_q[0].due != cyc) begin
      chk("sb_pin_present", 64'd0, 64'd1);
    end else begin
      e = pin_q.pop_front();
      chk("pins", {bus_if.vga_r, bus_if.vga_g, bus_if.vga_b, bus_if.vga_hs, bus_if.vga_vs,
                   bus_if.vga_blank_n, bus_if.frame_start, bus_if.vga_sync_n},
                  {e.r, e.g, e.b, e.hs, e.vs, e.act, e.fs, 1'b0});
      if (e.act && e.v == 0 && e.h == 224)
        chk("px_e0", {bus_if.vga_r, bus_if.vga_g, bus_if.vga_b}, 24'hFF0000);
      if (e.act && e.v == 0 && e.h == 73)
        chk("px_49", {bus_if.vga_r, bus_if.vga_g, bus_if.vga_b}, 24'h494955);
      if (e.act && e.v == 3 && e.h == 5)
        chk("px_5x3", {bus_if.vga_r, bus_if.vga_g, bus_if.vga_b}, 24'h0024AA);
      if (!e.act && e.v == 1 && e.h == 700)
        chk("porch_rgb", {bus_if.vga_r, bus_if.vga_g, bus_if.vga_b, bus_if.vga_blank_n}, 25'd0);
    end
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      a = addr_q.pop_front();
      chk("addr", {bus_if.r_x_address, bus_if.r_y_address}, {a.x, a.y});
    end
    while (dir_q.size() > 0 && dir_q[0].due <= cyc) begin
      d = dir_q.pop_front();
      if (d.due < cyc) chk("dir_stale", 64'(d.due), 64'(cyc));
      else chk(sig_name(d.sig), 64'(sig_val(d.sig)), 64'(d.exp));
    end
  end

  // Timing measurements on the pins while a steady scan is running.
  int   hs_len = -1, hs_per = -1, bl_len = -1, vs_len = -1, fs_per = -1, bl_lines = -1;
  logic p_hs = 1'b1, p_bl = 1'b0, p_vs = 1'b1;

  always begin
    @(negedge clk);
    #2;
    if (!meas_en) begin
      hs_len = -1; hs_per = -1; bl_len = -1; vs_len = -1; fs_per = -1; bl_lines = -1;
    end else begin
      if (hs_len >= 0) hs_len++;
      if (hs_per >= 0) hs_per++;
      if (bl_len >= 0) bl_len++;
      if (vs_len >= 0) vs_len++;
      if (fs_per >= 0) fs_per++;
      if (p_hs && !bus_if.vga_hs) begin
        if (hs_per >= 0) chk("hs_period", 64'(hs_per), 64'd800);
        hs_per = 0;
        hs_len = 0;
      end
      if (!p_hs && bus_if.vga_hs && hs_len >= 0) begin
        chk("hs_width", 64'(hs_len), 64'd96);
        hs_len = -1;
      end
      if (p_vs && !bus_if.vga_vs) vs_len = 0;
      if (!p_vs && bus_if.vga_vs && vs_len >= 0) begin
        chk("vs_width", 64'(vs_len), 64'd1600);
        vs_len = -1;
      end
      if (bus_if.frame_start) begin
        if (fs_per >= 0) begin
          chk("fs_period", 64'(fs_per), 64'(FRAME));
          chk("blank_lines", 64'(bl_lines), 64'(VA));
        end
        fs_per   = 0;
        bl_lines = 0;
      end
      if (!p_bl && bus_if.vga_blank_n) begin
        bl_len = 0;
        if (bl_lines >= 0) bl_lines++;
      end
      if (p_bl && !bus_if.vga_blank_n && bl_len >= 0) begin
        chk("blank_width", 64'(bl_len), 64'd640);
        bl_len = -1;
      end
    end
    p_hs = bus_if.vga_hs;
    p_bl = bus_if.vga_blank_n;
    p_vs = bus_if.vga_vs;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit found;
    rst_n = 1'b0;
    bus_if.enable = 1'b0;

    // Power-on reset, then a few disabled cycles.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("phase reset_release cyc=%0d", cyc);
    repeat (4) @(posedge clk);

    // First enable: scan starts at the origin.
    #1 bus_if.enable = 1'b1;
    t = cyc;
    $display("phase enable cyc=%0d", t);
    push_dir(t, SIG_X, 0);
    push_dir(t + 1, SIG_X, 1);
    push_dir(t + 1, SIG_FS, 0);
    push_dir(t + 2, SIG_FS, 1);
    push_dir(t + 2, SIG_BLANK, 1);
    meas_en = 1'b1;
    repeat (2 * FRAME + 2000) @(posedge clk);
    #1 meas_en = 1'b0;

    // Drop enable mid-line at h=300 of line 1.
    found = 1'b0;
    for (int i = 0; i < 10000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_h == 300 && m_v == 1) found = 1'b1;
    end
    chk("wait_drop", 64'(found), 64'd1);
    bus_if.enable = 1'b0;
    t = cyc;
    $display("phase enable_drop cyc=%0d", t);
    push_dir(t, SIG_X, 0);
    push_dir(t + 1, SIG_BLANK, 1);
    push_dir(t + 2, SIG_BLANK, 0);
    push_dir(t + 2, SIG_HS, 1);
    push_dir(t + 2, SIG_VS, 1);
    repeat (10) @(posedge clk);
    #1 bus_if.enable = 1'b1;
    t = cyc;
    $display("phase re_enable cyc=%0d", t);
    push_dir(t, SIG_X, 0);
    push_dir(t, SIG_Y, 0);
    push_dir(t + 1, SIG_X, 1);
    push_dir(t + 2, SIG_FS, 1);

    // Reset mid-scan at h=100 of line 2.
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_h == 100 && m_v == 2) found = 1'b1;
    end
    chk("wait_reset", 64'(found), 64'd1);
    rst_n = 1'b0;
    t = cyc;
    $display("phase mid_reset cyc=%0d", t);
    push_dir(t, SIG_BLANK, 0);
    push_dir(t, SIG_R, 0);
    push_dir(t, SIG_HS, 1);
    push_dir(t, SIG_VS, 1);
    push_dir(t, SIG_X, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    t = cyc;
    $display("phase reset_release2 cyc=%0d", t);
    push_dir(t + 1, SIG_X, 1);
    push_dir(t + 1, SIG_FS, 0);
    push_dir(t + 2, SIG_FS, 1);
    repeat (1500) @(posedge clk);

    repeat (3) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
